fwd_check_scheduler: RTL and testbench
======================================

// Module: fwd_check_scheduler
// PURPOSE
//  Shares one forwarding-decision datapath between NUM_REQ packet-handling requesters.
//  Grants one request at a time (round-robin) and fetches the 16-bit destination ID from the
//  byte-wide packet memory. Compares it against the node's own ID and returns a
//  forward/broadcast verdict to the granted requester. Sits between the ingress packet
//  handlers and the shared packet buffer read port.
// PARAMETERS
//  NUM_REQ      4        number of requesters
//  ADDR_WIDTH   10       packet memory address width (1024 bytes)
//  MEM_WIDTH    8        packet memory data width
//  WORD_WIDTH   16       node ID width
//  DEST_OFFSET  2        byte offset of destination ID from packet base
//  BCAST_ID     16'hFFFF broadcast destination ID
// PORTS
//  clock          in   1                   rising-edge clock
//  reset          in   1                   synchronous, active-high reset
//  my_node_id     in   WORD_WIDTH          this node's ID
//  req            in   NUM_REQ             request lines; held until granted
//  req_base_addr  in   NUM_REQ*ADDR_WIDTH  packed packet base address, slice i = requester i
//  grant          out  NUM_REQ             one-hot, 1-cycle pulse on acceptance
//  resp_valid     out  NUM_REQ             one-hot, 1-cycle pulse, verdict ready
//  resp_forward   out  1                   1 = dest ID == my_node_id or BCAST_ID
//  resp_bcast     out  1                   1 = dest ID == BCAST_ID
//  busy           out  1                   1 whenever FSM is not IDLE
//  mem_rd_en      out  1                   packet memory read strobe
//  mem_addr       out  ADDR_WIDTH          packet memory byte address
//  mem_rd_data    in   MEM_WIDTH           read data, valid 1 cycle after mem_rd_en
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, RR pointer=0. Reset mid-operation aborts silently;
//    no resp_valid is issued for the aborted request.
//  - FSM: IDLE -> RD_HI -> RD_LO -> CAP -> RESP -> IDLE. All outputs are registered.
//  - IDLE: on edge T with req!=0, pick the first set bit at or after the RR pointer
//    (wrapping). Latch idx, base address and my_node_id. Pointer <= (idx+1) mod NUM_REQ.
//  - Cycle T+1 (RD_HI): grant[idx]=1, busy=1, mem_rd_en=1, mem_addr=base+DEST_OFFSET.
//  - Cycle T+2 (RD_LO): mem_rd_en=1, mem_addr=base+DEST_OFFSET+1.
//    Capture mem_rd_data as the high byte.
//  - Cycle T+3 (CAP): mem_rd_en=0. Capture the low byte. Big-endian: high byte at the
//    lower address.
//  - Cycle T+4 (RESP): resp_valid[idx]=1; resp_forward and resp_bcast are valid this
//    cycle only and are 0 otherwise.
//  - Back to IDLE at T+5. A new request can be taken on the T+5 edge.
//    Max throughput: 1 verdict per 5 cycles.
//  - Address arithmetic is modulo 2^ADDR_WIDTH (wraps silently).
//  - req is sampled only in IDLE. Requests raised while busy wait. A req dropped before
//    grant is never served. A req still high after its resp is re-arbitrated normally.
//  - my_node_id changes after the latch edge do not affect the in-flight verdict.
//  - Simultaneous reset and req: reset wins; no grant is issued.
// STRUCTURE
//  - Shared package fwd_pkg: WORD_WIDTH, MEM_WIDTH, ADDR_WIDTH, BCAST_ID constants and
//    the FSM state encoding.
//  - Sub-module rr_arbiter (NUM_REQ): req + pointer -> one-hot pick and next pointer;
//    purely combinational, with the pointer register held in the parent.
//  - Comparator and byte assembly stay inline in the parent.
// TESTING
//  1. my_node_id=0x0012, req[0], base0=0x100, mem[0x102]=0x00, mem[0x103]=0x12
//     -> grant[0] at T+1; reads 0x102 then 0x103; resp_valid[0] at T+4;
//     resp_forward=1, resp_bcast=0.
//  2. Same setup as 1 with mem[0x103]=0x13 -> resp_valid[0] at T+4;
//     resp_forward=0, resp_bcast=0.
//  3. Destination bytes 0xFF, 0xFF -> resp_forward=1, resp_bcast=1.
//  4. req=4'b1111 held continuously -> grant order 0,1,2,3,0 at 5-cycle spacing;
//     exactly one resp_valid bit per RESP cycle.
//  5. base3=0x3FE, req[3] only -> mem_addr 0x000 then 0x001 (wrap);
//     verdict uses those bytes.
//  6. reset pulsed during RD_LO of a req[1] transaction -> next cycle all outputs 0,
//     no resp_valid[1]; then req[2] alone -> grant[2] (pointer reset to 0 skips
//     idle bits 0 and 1).

Source files
------------

// File: rtl/fwd_check_scheduler_pkg.sv
// Shared constants and FSM encoding for the forwarding-check scheduler.
package fwd_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int ADDR_WIDTH  = 10;
  localparam int MEM_WIDTH   = 8;
  localparam int WORD_WIDTH  = 16;
  localparam int DEST_OFFSET = 2;

  localparam logic [WORD_WIDTH-1:0] BCAST_ID = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_HI = 3'd1,
    ST_RD_LO = 3'd2,
    ST_CAP   = 3'd3,
    ST_RESP  = 3'd4
  } fsm_state_e;

  // Width of a requester index / round-robin pointer, never below one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fwd_check_scheduler_if.sv
// Requester-side bus: request lines, packet base addresses, node ID and the verdict returned.
interface fwd_check_scheduler_if
  import fwd_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
);

  logic [WORD_WIDTH-1:0]         my_node_id;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base_addr;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            resp_valid;
  logic                          resp_forward;
  logic                          resp_bcast;

  modport master (
    output my_node_id,
    output req,
    output req_base_addr,
    input  grant,
    input  resp_valid,
    input  resp_forward,
    input  resp_bcast
  );

  modport slave (
    input  my_node_id,
    input  req,
    input  req_base_addr,
    output grant,
    output resp_valid,
    output resp_forward,
    output resp_bcast
  );

endinterface

// File: rtl/fwd_check_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter
  import fwd_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int PTR_W  = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic               valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic [PTR_W-1:0]   next_ptr
);

  int               cand;
  logic [PTR_W-1:0] cand_idx;

  // Scan candidates in priority order starting at the pointer; the first hit wins.
  always_comb begin
    valid    = 1'b0;
    grant    = '0;
    idx      = '0;
    next_ptr = ptr;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = PTR_W'(cand);
      if (!valid && req[cand_idx]) begin
        valid           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
        next_ptr        = (cand == NUM_REQ - 1) ? '0 : PTR_W'(cand + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_check_scheduler.sv
// Time-shares one destination-ID fetch and compare between NUM_REQ packet handlers.
module fwd_check_scheduler
  import fwd_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic                  clock,
  input  logic                  reset,
  fwd_check_scheduler_if.slave  bus,
  output logic                  busy,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [MEM_WIDTH-1:0]  mem_rd_data
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  fsm_state_e            state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [WORD_WIDTH-1:0] node_q, node_d;
  logic [MEM_WIDTH-1:0]  hi_q, hi_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
  logic                  fwd_q, fwd_d;
  logic                  bcast_q, bcast_d;
  logic                  busy_q, busy_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic                  arb_valid;
  logic [NUM_REQ-1:0]    arb_grant;
  logic [PTR_W-1:0]      arb_idx;
  logic [PTR_W-1:0]      arb_next_ptr;
  logic [ADDR_WIDTH-1:0] sel_base;
  logic [NUM_REQ-1:0]    idx_onehot;
  logic [WORD_WIDTH-1:0] dest_id;
  logic                  dest_is_bcast;
  logic                  dest_is_mine;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req      (bus.req),
    .ptr      (ptr_q),
    .valid    (arb_valid),
    .grant    (arb_grant),
    .idx      (arb_idx),
    .next_ptr (arb_next_ptr)
  );

  // Pull the winning requester's base address out of the packed address bus.
  always_comb begin
    sel_base = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == PTR_W'(i)) begin
        sel_base = bus.req_base_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Big-endian destination ID: high byte was fetched first, low byte is arriving now.
  assign idx_onehot    = NUM_REQ'(1) << idx_q;
  assign dest_id       = {hi_q, mem_rd_data};
  assign dest_is_bcast = (dest_id == BCAST_ID);
  assign dest_is_mine  = (dest_id == node_q);

  // Next-state and next-output logic; every output is registered one cycle ahead.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    base_d       = base_q;
    node_d       = node_q;
    hi_d         = hi_q;
    grant_d      = '0;
    resp_valid_d = '0;
    fwd_d        = 1'b0;
    bcast_d      = 1'b0;
    busy_d       = 1'b0;
    rd_en_d      = 1'b0;
    addr_d       = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = ST_RD_HI;
          ptr_d   = arb_next_ptr;
          idx_d   = arb_idx;
          base_d  = sel_base;
          node_d  = bus.my_node_id;
          grant_d = arb_grant;
          busy_d  = 1'b1;
          rd_en_d = 1'b1;
          addr_d  = sel_base + ADDR_WIDTH'(DEST_OFFSET);
        end
      end
      ST_RD_HI: begin
        state_d = ST_RD_LO;
        busy_d  = 1'b1;
        rd_en_d = 1'b1;
        addr_d  = base_q + ADDR_WIDTH'(DEST_OFFSET + 1);
      end
      ST_RD_LO: begin
        state_d = ST_CAP;
        busy_d  = 1'b1;
        hi_d    = mem_rd_data;
      end
      ST_CAP: begin
        state_d      = ST_RESP;
        busy_d       = 1'b1;
        resp_valid_d = idx_onehot;
        fwd_d        = dest_is_mine || dest_is_bcast;
        bcast_d      = dest_is_bcast;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight request without a response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      idx_q        <= '0;
      base_q       <= '0;
      node_q       <= '0;
      hi_q         <= '0;
      grant_q      <= '0;
      resp_valid_q <= '0;
      fwd_q        <= 1'b0;
      bcast_q      <= 1'b0;
      busy_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      base_q       <= base_d;
      node_q       <= node_d;
      hi_q         <= hi_d;
      grant_q      <= grant_d;
      resp_valid_q <= resp_valid_d;
      fwd_q        <= fwd_d;
      bcast_q      <= bcast_d;
      busy_q       <= busy_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_forward = fwd_q;
  assign bus.resp_bcast   = bcast_q;
  assign busy             = busy_q;
  assign mem_rd_en        = rd_en_q;
  assign mem_addr         = addr_q;

endmodule

// File: tb/tb_fwd_check_scheduler.sv
// Scoreboard bench for fwd_check_scheduler: expected verdicts are queued when a request
// is primed and checked cycle by cycle as the scheduler walks through its transaction.
module tb_fwd_check_scheduler;
  import fwd_pkg::*;

  localparam int N = 4;

  typedef struct {
    int                    idx;
    logic [ADDR_WIDTH-1:0] base;
    logic                  fwd;
    logic                  bcast;
  } exp_t;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  busy;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [MEM_WIDTH-1:0]  mem_rd_data;
  logic [MEM_WIDTH-1:0]  mem [0:(1<<ADDR_WIDTH)-1];

  int   tests_run = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   phase     = 0;
  int   grants_seen = 0;
  bit   mon_en    = 1'b0;
  exp_t exp_q[$];
  exp_t cur;
  int   grant_cyc[$];

  fwd_check_scheduler_if #(.NUM_REQ(N)) bus ();

  fwd_check_scheduler #(.NUM_REQ(N)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Cycle counter used to measure grant spacing.
  always @(posedge clock) cyc <= cyc + 1;

  // Packet buffer model: one-cycle read latency.
  always @(posedge clock) begin
    if (reset) mem_rd_data <= '0;
    else if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  // Count one comparison and report it when the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Load the destination bytes and base address for a requester and queue its verdict.
  task automatic primeRequester(input int idx, input logic [ADDR_WIDTH-1:0] base,
                                input logic [WORD_WIDTH-1:0] node,
                                input logic [7:0] hi, input logic [7:0] lo);
    exp_t                  e;
    logic [ADDR_WIDTH-1:0] a;
    logic [WORD_WIDTH-1:0] dest;
    a = base + ADDR_WIDTH'(2);
    mem[a] = hi;
    a = a + ADDR_WIDTH'(1);
    mem[a] = lo;
    dest    = {hi, lo};
    e.idx   = idx;
    e.base  = base;
    e.bcast = (dest == 16'hFFFF);
    e.fwd   = (dest == node) || (dest == 16'hFFFF);
    bus.req_base_addr[idx*ADDR_WIDTH +: ADDR_WIDTH] = base;
    bus.my_node_id = node;
    exp_q.push_back(e);
  endtask

  // Single request: raise req until granted, disturb my_node_id, wait for the verdict.
  task automatic applyStimulus(input int idx, input logic [ADDR_WIDTH-1:0] base,
                               input logic [WORD_WIDTH-1:0] node,
                               input logic [7:0] hi, input logic [7:0] lo);
    bit got;
    primeRequester(idx, base, node, hi, lo);
    bus.req[idx] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clock); #1;
      if (bus.grant[idx]) got = 1'b1;
    end
    bus.req[idx]   = 1'b0;
    bus.my_node_id = ~node;
    if (!got) begin
      checkOutput("grant_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end else begin
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
        @(negedge clock); #1;
      end
      if (exp_q.size() != 0) begin
        checkOutput("resp_timeout", exp_q.size(), 32'd0);
        exp_q.delete();
      end
    end
  endtask

  // Transaction monitor: follows each grant through its read, capture and response cycles.
  always @(negedge clock) begin
    logic [ADDR_WIDTH-1:0] ea;
    if (!mon_en || reset) begin
      phase = 0;
    end else begin
      case (phase)
        0: begin
          if (bus.grant != '0) begin
            if (exp_q.size() == 0) begin
              checkOutput("grant_unexpected", bus.grant, 32'd0);
            end else begin
              cur = exp_q[0];
              ea  = cur.base + ADDR_WIDTH'(2);
              checkOutput("grant", bus.grant, 32'(1) << cur.idx);
              checkOutput("rd_hi_en", mem_rd_en, 32'd1);
              checkOutput("rd_hi_addr", mem_addr, ea);
              checkOutput("rd_hi_busy", busy, 32'd1);
              grants_seen++;
              grant_cyc.push_back(cyc);
              phase = 1;
            end
          end else begin
            checkOutput("idle_busy", busy, 32'd0);
            checkOutput("idle_resp", bus.resp_valid, 32'd0);
            checkOutput("idle_rd_en", mem_rd_en, 32'd0);
          end
        end
        1: begin
          ea = cur.base + ADDR_WIDTH'(3);
          checkOutput("rd_lo_en", mem_rd_en, 32'd1);
          checkOutput("rd_lo_addr", mem_addr, ea);
          checkOutput("rd_lo_grant", bus.grant, 32'd0);
          phase = 2;
        end
        2: begin
          checkOutput("cap_rd_en", mem_rd_en, 32'd0);
          checkOutput("cap_resp", bus.resp_valid, 32'd0);
          checkOutput("cap_busy", busy, 32'd1);
          phase = 3;
        end
        3: begin
          checkOutput("resp_valid", bus.resp_valid, 32'(1) << cur.idx);
          checkOutput("resp_forward", bus.resp_forward, cur.fwd);
          checkOutput("resp_bcast", bus.resp_bcast, cur.bcast);
          checkOutput("resp_busy", busy, 32'd1);
          void'(exp_q.pop_front());
          phase = 4;
        end
        default: begin
          checkOutput("post_busy", busy, 32'd0);
          checkOutput("post_resp", bus.resp_valid, 32'd0);
          checkOutput("post_forward", bus.resp_forward, 32'd0);
          checkOutput("post_bcast", bus.resp_bcast, 32'd0);
          checkOutput("post_grant", bus.grant, 32'd0);
          phase = 0;
        end
      endcase
    end
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    int start;
    bit got;
    reset             = 1'b1;
    bus.req           = '0;
    bus.req_base_addr = '0;
    bus.my_node_id    = '0;
    for (int i = 0; i < (1 << ADDR_WIDTH); i++) mem[i] = 8'h5A;
    repeat (3) @(negedge clock);
    #1;
    checkOutput("rst_grant", bus.grant, 32'd0);
    checkOutput("rst_resp", bus.resp_valid, 32'd0);
    checkOutput("rst_forward", bus.resp_forward, 32'd0);
    checkOutput("rst_bcast", bus.resp_bcast, 32'd0);
    checkOutput("rst_busy", busy, 32'd0);
    checkOutput("rst_rd_en", mem_rd_en, 32'd0);
    checkOutput("rst_addr", mem_addr, 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clock); #1;

    $display("[TB] own ID match, own ID mismatch, broadcast, address wrap");
    applyStimulus(0, 10'h100, 16'h0012, 8'h00, 8'h12);
    applyStimulus(0, 10'h100, 16'h0012, 8'h00, 8'h13);
    applyStimulus(2, 10'h200, 16'h0012, 8'hFF, 8'hFF);
    applyStimulus(3, 10'h3FE, 16'h0012, 8'h00, 8'h12);
    applyStimulus(1, 10'h3FD, 16'h1234, 8'h12, 8'h34);

    $display("[TB] all requests held: round-robin order");
    mon_en = 1'b0;
    @(negedge clock); #1 reset = 1'b1;
    @(negedge clock); #1 reset = 1'b0;
    mon_en = 1'b1;
    primeRequester(0, 10'h040, 16'h0012, 8'h00, 8'h12);
    primeRequester(1, 10'h080, 16'h0012, 8'hFF, 8'hFF);
    primeRequester(2, 10'h0C0, 16'h0012, 8'h12, 8'h00);
    primeRequester(3, 10'h140, 16'h0012, 8'h00, 8'h13);
    primeRequester(0, 10'h040, 16'h0012, 8'h00, 8'h12);
    grant_cyc.delete();
    start   = grants_seen;
    bus.req = 4'b1111;
    for (int k = 0; k < 60 && grants_seen < start + 5; k++) begin
      @(negedge clock); #1;
    end
    bus.req = '0;
    checkOutput("rr_grant_count", grants_seen - start, 32'd5);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(negedge clock); #1;
    end
    checkOutput("rr_drain", exp_q.size(), 32'd0);
    exp_q.delete();
    for (int i = 1; i < grant_cyc.size(); i++) begin
      checkOutput("rr_spacing", grant_cyc[i] - grant_cyc[i-1], 32'd5);
    end
    repeat (2) @(negedge clock);
    #1;

    $display("[TB] reset in the middle of a transaction");
    mon_en = 1'b0;
    bus.req_base_addr[1*ADDR_WIDTH +: ADDR_WIDTH] = 10'h180;
    mem[10'h182]   = 8'h00;
    mem[10'h183]   = 8'h12;
    bus.my_node_id = 16'h0012;
    bus.req        = 4'b0010;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clock); #1;
      if (bus.grant[1]) got = 1'b1;
    end
    checkOutput("abort_grant1", got, 32'd1);
    @(negedge clock); #1;
    checkOutput("abort_rd_lo_addr", mem_addr, 32'h183);
    reset   = 1'b1;
    bus.req = 4'b0100;
    @(negedge clock); #1;
    checkOutput("abort_grant", bus.grant, 32'd0);
    checkOutput("abort_resp", bus.resp_valid, 32'd0);
    checkOutput("abort_busy", busy, 32'd0);
    checkOutput("abort_rd_en", mem_rd_en, 32'd0);
    checkOutput("abort_addr", mem_addr, 32'd0);
    checkOutput("abort_forward", bus.resp_forward, 32'd0);
    reset   = 1'b0;
    bus.req = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock); #1;
      checkOutput("abort_no_resp", bus.resp_valid, 32'd0);
      checkOutput("abort_no_grant", bus.grant, 32'd0);
    end
    mon_en = 1'b1;
    applyStimulus(2, 10'h260, 16'h0012, 8'h00, 8'h12);

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
